// File: rtl/pipe_hazard_ctl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctl_pkg
// Purpose  : Shared encodings for the hazard/forwarding controller:
//            forward-select codes and the multi-cycle unit FSM states.
// Revision : 1.0  initial release
// ============================================================================
package pipe_hazard_ctl_pkg;

  // Operand source selects driven to the decode-stage operand muxes
  localparam logic [1:0] FWD_RF  = 2'b00;  // register file
  localparam logic [1:0] FWD_EX  = 2'b01;  // EX-stage ALU result
  localparam logic [1:0] FWD_MEM = 2'b10;  // MEM-stage ALU result
  localparam logic [1:0] FWD_LD  = 2'b11;  // MEM-stage load data

  // Multi-cycle execution unit occupancy
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } mc_state_e;

  // Latency counter width; MC_LAT is limited to 2..15
  localparam int MC_CNT_W = 4;

endpackage : pipe_hazard_ctl_pkg
`default_nettype wire

// File: rtl/pipe_hazard_ctl_fwd_sel.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctl_fwd_sel
// Purpose  : Per-operand forward select. Chooses the youngest non-load
//            producer; an EX-stage load is never a forward source because
//            its data does not exist yet (the top level stalls instead).
// Revision : 1.0  initial release
// ============================================================================
module pipe_hazard_ctl_fwd_sel
  import pipe_hazard_ctl_pkg::*;
#(
  parameter int RA_W = 5
) (
  input  logic            i_use,
  input  logic [RA_W-1:0] i_src,
  input  logic [RA_W-1:0] i_e_rn,
  input  logic            i_e_wreg,
  input  logic            i_e_m2reg,
  input  logic [RA_W-1:0] i_m_rn,
  input  logic            i_m_wreg,
  input  logic            i_m_m2reg,
  output logic [1:0]      o_fwd
);

  logic w_src_live;
  logic w_e_hit;
  logic w_m_hit;

  // r0 reads are constant zero, so they never take a forwarded value
  assign w_src_live = i_use & (i_src != '0);
  assign w_e_hit    = w_src_live & i_e_wreg & (i_src == i_e_rn);
  assign w_m_hit    = w_src_live & i_m_wreg & (i_src == i_m_rn);

  // Priority: EX ALU, then MEM ALU, then MEM load data, else register file
  always_comb begin
    o_fwd = FWD_RF;
    if (w_e_hit && !i_e_m2reg) begin
      o_fwd = FWD_EX;
    end else if (w_m_hit && !i_m_m2reg) begin
      o_fwd = FWD_MEM;
    end else if (w_m_hit && i_m_m2reg) begin
      o_fwd = FWD_LD;
    end
  end

endmodule : pipe_hazard_ctl_fwd_sel
`default_nettype wire

// File: rtl/pipe_hazard_ctl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctl
// Purpose  : Hazard and forwarding controller for the 5-stage pipeline.
//            Produces operand forward selects, load-use and multi-cycle
//            stalls, branch flushes, a mul/div occupancy scoreboard and a
//            saturating stall-cycle counter.
// Revision : 1.0  initial release
// ============================================================================
module pipe_hazard_ctl
  import pipe_hazard_ctl_pkg::*;
#(
  parameter int RA_W   = 5,
  parameter int MC_LAT = 4,   // 2..15
  parameter int CNT_W  = 16
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  id_rs,
  input  logic [RA_W-1:0]  id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_mc,
  input  logic [RA_W-1:0]  id_rd,
  input  logic             id_br,
  input  logic [RA_W-1:0]  e_rn,
  input  logic             e_wreg,
  input  logic             e_m2reg,
  input  logic [RA_W-1:0]  m_rn,
  input  logic             m_wreg,
  input  logic             m_m2reg,
  output logic [1:0]       fwda,
  output logic [1:0]       fwdb,
  output logic             wpcir,
  output logic             bubble,
  output logic             flush_if,
  output logic             mc_busy,
  output logic             mc_wb,
  output logic [RA_W-1:0]  mc_wn,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [MC_CNT_W-1:0] C_CNT_LOAD = MC_CNT_W'(MC_LAT - 1);
  localparam logic [CNT_W-1:0]    C_CNT_MAX  = {CNT_W{1'b1}};

  mc_state_e             state_q, state_d;
  logic [MC_CNT_W-1:0]   cnt_q, cnt_d;
  logic [RA_W-1:0]       mc_wn_q, mc_wn_d;
  logic                  mc_busy_q, mc_busy_d;
  logic                  mc_wb_q, mc_wb_d;
  logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;

  logic w_load_haz;
  logic w_mc_raw;
  logic w_mc_haz;
  logic w_stall;
  logic w_accept;

  pipe_hazard_ctl_fwd_sel #(.RA_W(RA_W)) u_fwd_a (
    .i_use     (id_use_rs),
    .i_src     (id_rs),
    .i_e_rn    (e_rn),
    .i_e_wreg  (e_wreg),
    .i_e_m2reg (e_m2reg),
    .i_m_rn    (m_rn),
    .i_m_wreg  (m_wreg),
    .i_m_m2reg (m_m2reg),
    .o_fwd     (fwda)
  );

  pipe_hazard_ctl_fwd_sel #(.RA_W(RA_W)) u_fwd_b (
    .i_use     (id_use_rt),
    .i_src     (id_rt),
    .i_e_rn    (e_rn),
    .i_e_wreg  (e_wreg),
    .i_e_m2reg (e_m2reg),
    .i_m_rn    (m_rn),
    .i_m_wreg  (m_wreg),
    .i_m_m2reg (m_m2reg),
    .o_fwd     (fwdb)
  );

  // Load in EX feeding a decode operand: data arrives one cycle too late
  assign w_load_haz = id_valid & e_wreg & e_m2reg & (e_rn != '0) &
                      ((id_use_rs & (id_rs == e_rn)) |
                       (id_use_rt & (id_rt == e_rn)));

  // Read of the pending mul/div destination (RAW) while the unit is occupied
  assign w_mc_raw = (mc_wn_q != '0) &
                    ((id_use_rs & (id_rs == mc_wn_q)) |
                     (id_use_rt & (id_rt == mc_wn_q)));

  // DRAIN still stalls: the regfile write happens in that same cycle
  assign w_mc_haz = id_valid & (state_q != IDLE) & (w_mc_raw | id_mc);

  assign w_stall  = w_load_haz | w_mc_haz;
  assign wpcir    = ~w_stall;
  assign bubble   = w_stall;
  // A stalled branch is held in decode and re-evaluated next cycle
  assign flush_if = id_br & ~w_stall;
  // Only IDLE can accept; stall here can only come from a load hazard
  assign w_accept = id_valid & id_mc & ~w_stall;

  assign mc_busy   = mc_busy_q;
  assign mc_wb     = mc_wb_q;
  assign mc_wn     = mc_wn_q;
  assign stall_cnt = stall_cnt_q;

  // Next-state for the mul/div scoreboard FSM, its registered outputs and the stall counter
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mc_wn_d     = mc_wn_q;
    mc_busy_d   = mc_busy_q;
    mc_wb_d     = 1'b0;
    stall_cnt_d = stall_cnt_q;

    case (state_q)
      IDLE: begin
        if (w_accept) begin
          state_d   = BUSY;
          cnt_d     = C_CNT_LOAD;
          mc_wn_d   = id_rd;
          mc_busy_d = 1'b1;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d = DRAIN;
          mc_wb_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DRAIN: begin
        state_d   = IDLE;
        mc_busy_d = 1'b0;
      end
      default: begin
        state_d   = IDLE;
        mc_busy_d = 1'b0;
      end
    endcase

    // Saturates rather than wrapping so long runs stay meaningful
    if (w_stall && (stall_cnt_q != C_CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // State and output registers; async reset abandons any in-flight mul/div
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mc_wn_q     <= '0;
      mc_busy_q   <= 1'b0;
      mc_wb_q     <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mc_wn_q     <= mc_wn_d;
      mc_busy_q   <= mc_busy_d;
      mc_wb_q     <= mc_wb_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule : pipe_hazard_ctl
`default_nettype wire
